// File: rtl/fma_pkg.sv
// Shared defaults, sequencer state type and abc packing helper for the fma operand sequencer.
package fma_pkg;

  localparam int unsigned WIDTH       = 16;
  localparam int unsigned FIXED_POINT = 10;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StZero
  } seq_state_t;

  function automatic logic [3*WIDTH-1:0] pack_abc(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [WIDTH-1:0] c);
    return {a, b, c};
  endfunction

endpackage

// File: rtl/fma_ab_fifo.sv
// Synchronous (a,b) pair FIFO; no bypass, so a pushed entry reaches the head on the next cycle.
module fma_ab_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_en, pop_en;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push_en && !pop_en) begin
        count_q <= count_q + CntW'(1);
      end else if (pop_en && !push_en) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fma_operand_sequencer.sv
// Issue stage for one fma lane: buffers (a,b) pairs and sequences one dot-product job at a time.
// Optional FMA_SEQ_STARVE_CNT_EN adds starve_cnt_out (ISSUE cycles spent with an empty FIFO).
module fma_operand_sequencer
  import fma_pkg::*;
#(
  parameter int unsigned WIDTH      = fma_pkg::WIDTH,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic [LEN_W-1:0]   job_len_in,
  input  logic [WIDTH-1:0]   job_bias_in,
  input  logic               job_valid_in,
  output logic               job_ready_out,
  input  logic [2*WIDTH-1:0] ab_in,
  input  logic               ab_valid_in,
  output logic               ab_ready_out,
  output logic [3*WIDTH-1:0] abc_out,
  output logic               valid_out,
  output logic               c_valid_out,
  output logic               output_can_be_valid_out,
  output logic               busy_out,
`ifdef FMA_SEQ_STARVE_CNT_EN
  output logic [15:0]        starve_cnt_out,
`endif
  output logic               done_out
);

  seq_state_t         state_q;
  logic [LEN_W-1:0]   remaining_q;
  logic [WIDTH-1:0]   bias_q;
  logic               first_q;
  logic               fifo_full, fifo_empty, pop;
  logic [2*WIDTH-1:0] fifo_head;
  logic               last_beat;

  fma_ab_fifo #(
    .Width (2 * WIDTH),
    .Depth (FIFO_DEPTH)
  ) u_ab_fifo (
    .clk_i   (clk_in),
    .rst_ni  (rst_n_in),
    .push_i  (ab_valid_in),
    .data_i  (ab_in),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign job_ready_out = (state_q == StIdle);
  assign busy_out      = (state_q != StIdle);
  assign ab_ready_out  = !fifo_full;
  assign pop           = (state_q == StIssue) && !fifo_empty;
  assign last_beat     = (remaining_q == LEN_W'(1));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q                 <= StIdle;
      remaining_q             <= '0;
      bias_q                  <= '0;
      first_q                 <= 1'b0;
      abc_out                 <= '0;
      valid_out               <= 1'b0;
      c_valid_out             <= 1'b0;
      output_can_be_valid_out <= 1'b0;
      done_out                <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          valid_out               <= 1'b0;
          c_valid_out             <= 1'b0;
          output_can_be_valid_out <= 1'b0;
          done_out                <= 1'b0;
          if (job_valid_in) begin
            bias_q      <= job_bias_in;
            remaining_q <= job_len_in;
            first_q     <= 1'b1;
            state_q     <= (job_len_in == '0) ? StZero : StIssue;
          end
        end
        StIssue: begin
          if (pop) begin
            abc_out                 <= {fifo_head, bias_q};
            valid_out               <= 1'b1;
            c_valid_out             <= first_q;
            output_can_be_valid_out <= last_beat;
            done_out                <= last_beat;
            first_q                 <= 1'b0;
            remaining_q             <= remaining_q - LEN_W'(1);
            if (last_beat) state_q <= StIdle;
          end else begin
            // Starved: hold the pins, just drop valid until a pair arrives.
            valid_out <= 1'b0;
            done_out  <= 1'b0;
          end
        end
        StZero: begin
          // Zero-length job: a*b = 0 so the lane returns the bias alone.
          abc_out                 <= {{(2 * WIDTH){1'b0}}, bias_q};
          valid_out               <= 1'b1;
          c_valid_out             <= 1'b1;
          output_can_be_valid_out <= 1'b1;
          done_out                <= 1'b1;
          first_q                 <= 1'b0;
          state_q                 <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef FMA_SEQ_STARVE_CNT_EN
  logic [15:0] starve_cnt_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      starve_cnt_q <= '0;
    end else if ((state_q == StIdle) && job_valid_in) begin
      starve_cnt_q <= '0;
    end else if ((state_q == StIssue) && fifo_empty && (starve_cnt_q != 16'hFFFF)) begin
      starve_cnt_q <= starve_cnt_q + 16'd1;
    end
  end

  assign starve_cnt_out = starve_cnt_q;
`endif

endmodule

// File: tb/tb_fma_operand_sequencer.sv
// Self-checking bench: directed table, multi-cycle corner sequences, randomized scoreboard.
module tb_fma_operand_sequencer;
  import fma_pkg::*;

  localparam int unsigned D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  job_len = '0;
  logic [15:0] job_bias = '0;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [31:0] ab = '0;
  logic        ab_valid = 1'b0;
  logic        ab_ready;
  logic [47:0] abc;
  logic        valid, c_valid, ocbv, busy, done;
`ifdef FMA_SEQ_STARVE_CNT_EN
  logic [15:0] starve_cnt;
`endif

  fma_operand_sequencer #(
    .WIDTH      (16),
    .LEN_W      (8),
    .FIFO_DEPTH (D)
  ) dut (
    .clk_in                  (clk),
    .rst_n_in                (rst_n),
    .job_len_in              (job_len),
    .job_bias_in             (job_bias),
    .job_valid_in            (job_valid),
    .job_ready_out           (job_ready),
    .ab_in                   (ab),
    .ab_valid_in             (ab_valid),
    .ab_ready_out            (ab_ready),
    .abc_out                 (abc),
    .valid_out               (valid),
    .c_valid_out             (c_valid),
    .output_can_be_valid_out (ocbv),
    .busy_out                (busy),
`ifdef FMA_SEQ_STARVE_CNT_EN
    .starve_cnt_out          (starve_cnt),
`endif
    .done_out                (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Behavioural fma lane: acc = c (on c_valid) plus fixed-point a*b, result on ocbv.
  logic [15:0] fma_acc = '0;
  task automatic fma_beat(output bit got, output logic [15:0] res);
    logic [15:0]        a, b, c;
    logic signed [31:0] p;
    {a, b, c} = abc;
    p = $signed(a) * $signed(b);
    p = p >>> FIXED_POINT;
    fma_acc = (c_valid ? c : fma_acc) + p[15:0];
    got = ocbv;
    res = fma_acc;
  endtask

  typedef struct packed {
    logic [7:0]       len;
    logic [15:0]      bias;
    logic [2:0]       npairs;
    logic [3:0][31:0] pairs;
    logic [15:0]      exp_res;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] len, input logic [15:0] bias,
                              input logic [2:0] np, input logic [31:0] p0,
                              input logic [31:0] p1, input logic [31:0] p2,
                              input logic [31:0] p3, input logic [15:0] res);
    vec_t v;
    v.len = len; v.bias = bias; v.npairs = np;
    v.pairs[0] = p0; v.pairs[1] = p1; v.pairs[2] = p2; v.pairs[3] = p3;
    v.exp_res = res;
    return v;
  endfunction

  vec_t vecs [5];

  task automatic run_vec(input vec_t v, input string tag);
    int   nbeats, first_c, last_c, exp_beats;
    bit   fin, got, got_res, last;
    logic [15:0] res, result;
    logic [47:0] exp_abc;
    nbeats = 0; fin = 0; got_res = 0; first_c = 0; last_c = 0; result = '0;
    exp_beats = (v.len == 0) ? 1 : int'(v.len);
    for (int i = 0; i < int'(v.npairs); i++) begin
      ab_valid = 1'b1;
      ab = v.pairs[i];
      step();
    end
    ab_valid = 1'b0;
    if (v.npairs == 3'(D)) chk({tag, " ab_ready at full"}, 64'(ab_ready), 64'(0));
    job_valid = 1'b1; job_len = v.len; job_bias = v.bias;
    step();
    job_valid = 1'b0;
    for (int c = 0; c < 50 && !fin; c++) begin
      if (v.npairs == 3'(D) && c == 0) chk({tag, " ab_ready before pop"}, 64'(ab_ready), 64'(0));
      if (valid) begin
        last = (v.len == 0) || (nbeats >= int'(v.len) - 1);
        if (v.len == 0) exp_abc = pack_abc(16'h0, 16'h0, v.bias);
        else if (nbeats < 4)
          exp_abc = pack_abc(v.pairs[nbeats][31:16], v.pairs[nbeats][15:0], v.bias);
        else exp_abc = '0;
        chk({tag, " abc"}, 64'(abc), 64'(exp_abc));
        chk({tag, " c_valid"}, 64'(c_valid), 64'(nbeats == 0));
        chk({tag, " ocbv"}, 64'(ocbv), 64'(last));
        chk({tag, " done"}, 64'(done), 64'(last));
        if (v.npairs == 3'(D) && nbeats == 0)
          chk({tag, " ab_ready after pop"}, 64'(ab_ready), 64'(1));
        fma_beat(got, res);
        if (got) begin got_res = 1; result = res; end
        if (nbeats == 0) first_c = c;
        if (last) begin last_c = c; fin = 1; end
        nbeats++;
      end else begin
        chk({tag, " no stray done"}, 64'(done), 64'(0));
      end
      if (!fin) step();
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL %s timeout: got %0d beats required %0d", tag, nbeats, exp_beats);
    end
    chk({tag, " result valid"}, 64'(got_res), 64'(1));
    chk({tag, " fma result"}, 64'(result), 64'(v.exp_res));
    chk({tag, " back-to-back span"}, 64'(last_c - first_c), 64'(exp_beats - 1));
    step();
    chk({tag, " idle valid"}, 64'(valid), 64'(0));
    chk({tag, " idle busy"}, 64'(busy), 64'(0));
  endtask

  // Randomized scoreboard state.
  typedef struct packed {
    logic [7:0]  len;
    logic [15:0] bias;
  } job_t;
  job_t        jobs_q[$];
  logic [31:0] pairs_q[$];
  int          rnd_idx = 0;

  task automatic rnd_monitor();
    job_t        j;
    logic [31:0] p;
    logic [47:0] exp_abc;
    bit          last;
    if (valid) begin
      if (jobs_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rnd stray beat: got abc %0h required no beat", abc);
      end else begin
        j = jobs_q[0];
        if (j.len == 0) begin
          exp_abc = pack_abc(16'h0, 16'h0, j.bias);
          last = 1;
        end else begin
          if (pairs_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rnd beat without pair: got abc %0h required none", abc);
            p = '0;
          end else p = pairs_q.pop_front();
          exp_abc = pack_abc(p[31:16], p[15:0], j.bias);
          last = (rnd_idx == int'(j.len) - 1);
        end
        chk("rnd abc", 64'(abc), 64'(exp_abc));
        chk("rnd c_valid", 64'(c_valid), 64'(rnd_idx == 0));
        chk("rnd ocbv", 64'(ocbv), 64'(last));
        chk("rnd done", 64'(done), 64'(last));
        if (last) begin
          void'(jobs_q.pop_front());
          rnd_idx = 0;
        end else rnd_idx++;
      end
    end else begin
      chk("rnd idle done", 64'(done), 64'(0));
    end
    chk("rnd busy", 64'(busy), 64'(jobs_q.size() != 0));
  endtask

  initial begin
    bit          got;
    logic [15:0] res;
    logic [15:0] results [2];
    int          nres;
    bit          seen;

    vecs[0] = mk(8'd3, 16'h0400, 3'd3, 32'h0800_0400, 32'h0400_0400, 32'h0C00_0200, 32'h0,
                 16'h1600);
    vecs[1] = mk(8'd0, 16'h0A00, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 16'h0A00);
    vecs[2] = mk(8'd4, 16'h0000, 3'd4, 32'h0400_0400, 32'h0400_0400, 32'h0400_0400,
                 32'h0400_0400, 16'h1000);
    vecs[3] = mk(8'd1, 16'h0000, 3'd1, 32'h0C00_0800, 32'h0, 32'h0, 32'h0, 16'h1800);
    vecs[4] = mk(8'd2, 16'h0400, 3'd2, 32'h0400_0400, 32'h0200_0800, 32'h0, 32'h0, 16'h0C00);

    // Reset values
    step(); step();
    chk("reset job_ready", 64'(job_ready), 64'(1));
    chk("reset ab_ready", 64'(ab_ready), 64'(1));
    chk("reset outputs", 64'({abc, valid, c_valid, ocbv, busy, done}), 64'(0));
`ifdef FMA_SEQ_STARVE_CNT_EN
    chk("reset starve", 64'(starve_cnt), 64'(0));
`endif
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Starved job: pairs 3 cycles apart.
    for (int k = 0; k < 8; k++) begin
      job_valid = (k == 0); job_len = 8'd2; job_bias = 16'h0400;
      ab_valid = (k == 2) || (k == 5);
      ab = (k == 2) ? 32'h0400_0400 : 32'h0800_0200;
      step();
      chk($sformatf("t4 valid c%0d", k), 64'(valid), 64'((k == 3) || (k == 6)));
      chk($sformatf("t4 done c%0d", k), 64'(done), 64'(k == 6));
      if (valid) begin
        chk($sformatf("t4 c_valid c%0d", k), 64'(c_valid), 64'(k == 3));
        chk($sformatf("t4 abc c%0d", k), 64'(abc),
            64'((k == 3) ? pack_abc(16'h0400, 16'h0400, 16'h0400)
                         : pack_abc(16'h0800, 16'h0200, 16'h0400)));
        fma_beat(got, res);
        if (got) chk("t4 fma result", 64'(res), 64'(16'h0C00));
      end
    end
    job_valid = 1'b0; ab_valid = 1'b0;
`ifdef FMA_SEQ_STARVE_CNT_EN
    chk("t4 starve count", 64'(starve_cnt), 64'(4));
`endif

    // Back-to-back jobs: exactly one idle bubble between them.
    for (int i = 0; i < 3; i++) begin
      ab_valid = 1'b1;
      ab = (i == 0) ? 32'h0800_0400 : (i == 1) ? 32'h0400_0400 : 32'h0400_0800;
      step();
    end
    ab_valid = 1'b0;
    nres = 0;
    for (int k = 0; k < 6; k++) begin
      job_valid = (k <= 2);
      job_len = (k == 0) ? 8'd1 : 8'd2;
      job_bias = (k == 0) ? 16'h0000 : 16'h0400;
      step();
      chk($sformatf("t5 valid c%0d", k), 64'(valid), 64'((k == 1) || (k == 3) || (k == 4)));
      chk($sformatf("t5 job_ready c%0d", k), 64'(job_ready), 64'((k == 1) || (k >= 4)));
      chk($sformatf("t5 done c%0d", k), 64'(done), 64'((k == 1) || (k == 4)));
      if (valid) begin
        chk($sformatf("t5 c_valid c%0d", k), 64'(c_valid), 64'(k != 4));
        fma_beat(got, res);
        if (got && nres < 2) begin results[nres] = res; nres++; end
      end
    end
    job_valid = 1'b0;
    chk("t5 result count", 64'(nres), 64'(2));
    if (nres == 2) begin
      chk("t5 result 1", 64'(results[0]), 64'(16'h0800));
      chk("t5 result 2", 64'(results[1]), 64'(16'h1000));
    end

    // Mid-job reset after the first of three beats.
    for (int i = 0; i < 3; i++) begin
      ab_valid = 1'b1; ab = vecs[0].pairs[i];
      step();
    end
    ab_valid = 1'b0;
    job_valid = 1'b1; job_len = 8'd3; job_bias = 16'h0400;
    step();
    job_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (valid) seen = 1;
      else step();
    end
    chk("t6 first beat seen", 64'(seen), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("t6 outputs cleared", 64'({abc, valid, c_valid, ocbv, busy, done}), 64'(0));
    chk("t6 job_ready", 64'(job_ready), 64'(1));
    chk("t6 ab_ready", 64'(ab_ready), 64'(1));
    step(); step();
    rst_n = 1'b1;
    step();
    run_vec(vecs[0], "t6 after reset");

    // Randomized traffic against the transaction scoreboard.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rnd_monitor();
      if (cyc >= 2500 && jobs_q.size() == 0) break;
      ab_valid = 1'($urandom_range(0, 1));
      ab = $urandom;
      job_valid = (cyc < 2500) && ($urandom_range(0, 3) == 0);
      job_len = 8'($urandom_range(0, 6));
      job_bias = 16'($urandom);
      if (ab_valid && ab_ready) pairs_q.push_back(ab);
      if (job_valid && job_ready) jobs_q.push_back({job_len, job_bias});
      step();
    end
    ab_valid = 1'b0; job_valid = 1'b0;
    chk("rnd all jobs drained", 64'(jobs_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
